uart_sender_cfg: RTL and testbench

UART_SENDER_CFG -- requirements
Module: uart_sender_cfg

---
 rtl/uart_sender_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_sender_cfg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_sender_cfg.sv
// Parameterized UART transmitter: start bit, LSB-first data, optional parity,
// 1 or 2 stop bits, then a one-cycle CLEAN_UP state that pulses done.
module uart_sender_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $fatal(1, "uart_sender_cfg: CLKS_PER_BIT out of range 2..65535");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
    $fatal(1, "uart_sender_cfg: DATA_WIDTH out of range 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $fatal(1, "uart_sender_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_sender_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int             CW            = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     IDX_DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]     IDX_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           PAR_ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, CLEAN_UP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Outputs are registered: tx/busy/done are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shreg_d = data_in;
          par_d   = (^data_in) ^ PAR_ODD;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_DATA_LAST) begin
            idx_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = PARITY_BIT;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP_BIT;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY_BIT: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP_BIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = CLEAN_UP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAN_UP: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_sender_cfg.sv
// Directed bench: three configurations share clk/rst_n; frames checked cycle by cycle.
module tb_uart_sender_cfg;

  logic       clk;
  logic       rst_n;
  logic [8:0] data;
  logic       start_v [3];
  logic       tx_v    [3];
  logic       busy_v  [3];
  logic       done_v  [3];

  int errors = 0;
  int checks = 0;

  // cfg 0: 8N1, cfg 1: 7E2, cfg 2: 8O1 -- all at 4 clocks per bit
  uart_sender_cfg #(.CLKS_PER_BIT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data_in(data[7:0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_sender_cfg #(.CLKS_PER_BIT(4), .DATA_WIDTH(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data_in(data[6:0]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_sender_cfg #(.CLKS_PER_BIT(4), .PARITY(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .data_in(data[7:0]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cfg;
    logic [8:0] data;
    int         nbits;
    logic [15:0] bits;   // bit i = i-th bit on the line, start bit first
    bit         noise;   // extra start pulses during START_BIT and STOP_BIT
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%b exp=%b", name, k, act, exp);
    end
  endtask

  task automatic chk_idle_all(input string name);
    for (int i = 0; i < 3; i++) begin
      chk({name, "_tx"}, i, tx_v[i], 1'b1);
      chk({name, "_busy"}, i, busy_v[i], 1'b0);
      chk({name, "_done"}, i, done_v[i], 1'b0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int n;
    n = v.nbits * 4;
    @(negedge clk);
    data = v.data;
    start_v[v.cfg] = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= n + 3; k++) begin
      @(negedge clk);
      start_v[v.cfg] = 1'b0;
      data = 9'($urandom);
      if (k < n) begin
        chk("tx", k, tx_v[v.cfg], v.bits[k/4]);
        chk("busy", k, busy_v[v.cfg], 1'b1);
        chk("done", k, done_v[v.cfg], 1'b0);
      end else begin
        chk("tx_end", k, tx_v[v.cfg], 1'b1);
        chk("busy_end", k, busy_v[v.cfg], 1'b0);
        chk("done_end", k, done_v[v.cfg], (k == n) ? 1'b1 : 1'b0);
      end
      if (v.noise && (k == 1 || k == n - 3)) start_v[v.cfg] = 1'b1;
    end
  endtask

  function automatic logic [15:0] frame8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  initial begin
    logic [7:0]  bb_data [3];
    logic [15:0] exp_bits;
    int          ndone;
    vec_t        v;

    vecs[0] = '{0, 9'h07F, 10, 16'h02FE, 1'b0};
    vecs[1] = '{0, 9'h0A5, 10, 16'h034A, 1'b0};
    vecs[2] = '{1, 9'h055, 11, 16'h06AA, 1'b0};
    vecs[3] = '{2, 9'h000, 11, 16'h0600, 1'b0};
    vecs[4] = '{2, 9'h001, 11, 16'h0402, 1'b0};
    vecs[5] = '{0, 9'h07F, 10, 16'h02FE, 1'b1};

    rst_n = 1'b0;
    data  = '0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    #12;
    chk_idle_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_all("post_reset");

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // start held high across three frames; data wanders between acceptances
    bb_data[0] = 8'h3C; bb_data[1] = 8'hC3; bb_data[2] = 8'h81;
    ndone = 0;
    @(negedge clk);
    data = {1'b0, bb_data[0]};
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3 * 42 + 4; k++) begin
      int f, r;
      @(negedge clk);
      f = k / 42;
      r = k % 42;
      if (done_v[0]) ndone++;
      if (f < 3) begin
        exp_bits = frame8n1(bb_data[f]);
        if (r < 40) begin
          chk("bb_tx", k, tx_v[0], exp_bits[r/4]);
          chk("bb_busy", k, busy_v[0], 1'b1);
        end else begin
          chk("bb_done", k, done_v[0], (r == 40) ? 1'b1 : 1'b0);
          chk("bb_busy_gap", k, busy_v[0], 1'b0);
        end
      end else begin
        chk("bb_after_busy", k, busy_v[0], 1'b0);
      end
      if (r == 41 && f < 2) data = {1'b0, bb_data[f+1]};
      else data = 9'($urandom);
      if (k == 3 * 42 - 2) start_v[0] = 1'b0;
    end
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL bb_done_count got=%0d exp=3", ndone);
    end

    // asynchronous reset while data bit 3 is on the line
    @(negedge clk);
    data = 9'h0A5;
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    chk("pre_rst_tx", 17, tx_v[0], 1'b0);   // 0xA5 bit 3 = 0
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", 0, tx_v[0], 1'b1);
    chk("rst_busy", 0, busy_v[0], 1'b0);
    chk("rst_done", 0, done_v[0], 1'b0);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL rst_no_done_busy got=%0d exp=0", ndone);
    end
    v = vecs[0];
    run_frame(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
